// File: rtl/xmtr.sv
// ---------------------------------------------------------------------------
// xmtr -- framed serial transmitter
//
// Accepts parallel bytes into a one-deep holding register and sends each one
// as a 16-bit frame, MSB first: the HEADER byte followed by the data byte.
// A second byte can be queued while the current frame is shifting out, which
// gives back-to-back frames with no idle bit between them.
//
// Ports:
//   clock    : rising-edge clock for all state
//   reset    : synchronous, active-high reset
//   data_in  : byte to transmit, captured when writing && ready
//   writing  : write strobe, one byte offered per high cycle
//   data_out : registered serial output, one bit per cycle (0 when idle)
//   ready    : holding register empty
//   overrun  : sticky, a write was dropped because the holding register was full
//   busy     : a frame is in progress (any HEAD or BODY state)
// ---------------------------------------------------------------------------
module xmtr #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       writing,
    output logic       data_out,
    output logic       ready,
    output logic       overrun,
    output logic       busy
);

    // Encoding is the bit position in the frame, so the bit index of any
    // HEAD or BODY state is simply the low three bits of (16 - state).
    typedef enum logic [4:0] {
        S_IDLE  = 5'd0,
        S_HEAD1 = 5'd1,  S_HEAD2 = 5'd2,  S_HEAD3 = 5'd3,  S_HEAD4 = 5'd4,
        S_HEAD5 = 5'd5,  S_HEAD6 = 5'd6,  S_HEAD7 = 5'd7,  S_HEAD8 = 5'd8,
        S_BODY1 = 5'd9,  S_BODY2 = 5'd10, S_BODY3 = 5'd11, S_BODY4 = 5'd12,
        S_BODY5 = 5'd13, S_BODY6 = 5'd14, S_BODY7 = 5'd15, S_BODY8 = 5'd16
    } state_t;

    state_t     state_q,    state_d;
    logic [7:0] hold_q,     hold_d;
    logic [7:0] shift_q,    shift_d;
    logic       ready_q,    ready_d;
    logic       overrun_q,  overrun_d;
    logic       data_out_q, data_out_d;
    logic       busy_q,     busy_d;

    logic       accept_s;
    logic       enter_head1_s;
    logic [2:0] bit_idx_s;

    // Next-state, storage and output-bit computation.
    always_comb begin
        accept_s = writing && ready_q;

        // Transition decisions look only at the pre-edge ready value, so a
        // write landing on this same edge cannot start a frame early.
        case (state_q)
            S_IDLE, S_BODY8: begin
                if (ready_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HEAD1;
                end
            end
            S_HEAD1, S_HEAD2, S_HEAD3, S_HEAD4, S_HEAD5, S_HEAD6, S_HEAD7,
            S_HEAD8, S_BODY1, S_BODY2, S_BODY3, S_BODY4, S_BODY5, S_BODY6,
            S_BODY7: begin
                state_d = state_t'(5'(state_q) + 5'd1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enter_head1_s = (state_d == S_HEAD1);

        if (accept_s) begin
            hold_d = data_in;
        end else begin
            hold_d = hold_q;
        end

        if (enter_head1_s) begin
            shift_d = hold_q;
        end else begin
            shift_d = shift_q;
        end

        // Entering HEAD1 requires ready_q=0 and accepting requires
        // ready_q=1, so the two branches never compete.
        if (enter_head1_s) begin
            ready_d = 1'b1;
        end else if (accept_s) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        if (accept_s) begin
            overrun_d = 1'b0;
        end else if (writing) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        bit_idx_s = 3'(5'd16 - 5'(state_d));

        // The bit is chosen from the next state so it lands with that state.
        // BODY bits read shift_q, which was loaded on entry to HEAD1.
        if (state_d == S_IDLE) begin
            data_out_d = 1'b0;
        end else if (5'(state_d) <= 5'(S_HEAD8)) begin
            data_out_d = HEADER[bit_idx_s];
        end else begin
            data_out_d = shift_q[bit_idx_s];
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset overrides any same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= 8'h00;
            shift_q    <= 8'h00;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_xmtr.sv
// ---------------------------------------------------------------------------
// tb_xmtr -- directed and scoreboard bench for xmtr.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so each sample shows the state after that edge.
// ---------------------------------------------------------------------------
module tb_xmtr;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       writing = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_out;
    logic       ready;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    xmtr #(.HEADER(8'hA5)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .writing  (writing),
        .data_out (data_out),
        .ready    (ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present inputs for one edge, then return 1 unit after it.
    task automatic step(input logic wr, input logic [7:0] d, input logic rst);
        writing = wr;
        data_in = d;
        reset   = rst;
        @(posedge clock);
        #1;
        writing = 1'b0;
        reset   = 1'b0;
    endtask

    logic [63:0] got;
    logic        busy_all;
    logic [7:0]  sb_q[$];
    logic [15:0] sr;
    int          bit_cnt;
    int          frames;

    initial begin
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_val("rst_ready",    ready,    1);
        check_val("rst_busy",     busy,     0);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_overrun",  overrun,  0);

        // Single frame 0x3C from idle.
        step(1'b1, 8'h3C, 1'b0);
        check_val("t1_ready_low", ready, 0);
        check_val("t1_busy_e0",   busy,  0);
        got = '0; busy_all = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 8'h00, 1'b0);
            got = {got[62:0], data_out};
            busy_all = busy_all & busy;
            if (e == 1) check_val("t1_ready_back", ready, 1);
        end
        check_val("t1_stream", got[15:0], 16'hA53C);
        check_val("t1_busy",   busy_all,  1);
        step(1'b0, 8'h00, 1'b0);
        check_val("t1_idle_bit",  data_out, 0);
        check_val("t1_idle_busy", busy,     0);

        // Back-to-back: 0x11 at edge 0, 0x22 at edge 4.
        got = '0;
        for (int e = 0; e <= 32; e++) begin
            step((e == 0) || (e == 4), (e == 0) ? 8'h11 : 8'h22, 1'b0);
            if (e >= 1) got = {got[62:0], data_out};
            if (e == 17) check_val("t2_head1_busy", busy, 1);
        end
        check_val("t2_stream",  got[31:0], 32'hA511A522);
        check_val("t2_overrun", overrun,   0);
        step(1'b0, 8'h00, 1'b0);
        check_val("t2_end_busy", busy, 0);

        // Overrun: third write at edge 5 is dropped.
        got = '0;
        for (int e = 0; e <= 32; e++) begin
            step((e == 0) || (e == 4) || (e == 5),
                 (e == 0) ? 8'h11 : ((e == 4) ? 8'h22 : 8'h33), 1'b0);
            if (e >= 1) got = {got[62:0], data_out};
            if (e == 4) check_val("t3_ovr_before", overrun, 0);
            if (e == 5) check_val("t3_ovr_set",    overrun, 1);
        end
        check_val("t3_stream", got[31:0], 32'hA511A522);
        step(1'b0, 8'h00, 1'b0);
        check_val("t3_ovr_hold", overrun, 1);
        check_val("t3_idle",     busy,    0);
        step(1'b1, 8'h44, 1'b0);
        check_val("t3_ovr_clear", overrun, 0);
        for (int e = 0; e < 17; e++) step(1'b0, 8'h00, 1'b0);
        check_val("t3_drain", busy, 0);

        // Write in BODY8 cycle: exactly one idle bit between frames.
        got = '0;
        for (int e = 0; e <= 33; e++) begin
            step((e == 0) || (e == 17), (e == 0) ? 8'h3C : 8'h5A, 1'b0);
            if (e >= 1) got = {got[62:0], data_out};
            if (e == 17) begin
                check_val("t4_gap_busy",  busy,  0);
                check_val("t4_gap_ready", ready, 0);
            end
        end
        check_val("t4_stream", got[32:0], {16'hA53C, 1'b0, 16'hA55A});
        step(1'b0, 8'h00, 1'b0);

        // Reset mid-frame with 0x55 queued, plus a write during reset.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check_val("t5_queued", ready, 0);
        for (int e = 3; e <= 7; e++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b1);
        check_val("t5_rst_ready",    ready,    1);
        check_val("t5_rst_busy",     busy,     0);
        check_val("t5_rst_data_out", data_out, 0);
        check_val("t5_rst_overrun",  overrun,  0);
        step(1'b0, 8'h00, 1'b0);
        check_val("t5_still_idle",  busy,  0);
        check_val("t5_still_ready", ready, 1);
        step(1'b1, 8'hF0, 1'b0);
        got = '0;
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 8'h00, 1'b0);
            got = {got[62:0], data_out};
        end
        check_val("t5_stream", got[15:0], 16'hA5F0);
        step(1'b0, 8'h00, 1'b0);
        check_val("t5_end_busy", busy, 0);

        // Random traffic decoded from the stream against accepted writes.
        bit_cnt = 0;
        frames  = 0;
        sr      = '0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            logic       wr;
            logic [7:0] d;
            if (cyc >= 5500)
                wr = 1'b0;
            else if (((cyc / 500) % 2) == 1)
                wr = ($urandom_range(0, 39) == 0);
            else
                wr = ($urandom_range(0, 2) == 0);
            d = 8'($urandom);
            if (wr && ready) sb_q.push_back(d);
            step(wr, d, 1'b0);
            if (busy) begin
                sr = {sr[14:0], data_out};
                bit_cnt++;
                if (bit_cnt == 16) begin
                    frames++;
                    check_val("rnd_header", sr[15:8], 8'hA5);
                    check_val("rnd_frame_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) check_val("rnd_body", sr[7:0], sb_q.pop_front());
                    bit_cnt = 0;
                end
            end else begin
                if (bit_cnt != 0) check_val("rnd_partial_frame", bit_cnt, 0);
                bit_cnt = 0;
            end
        end
        check_val("rnd_queue_empty", sb_q.size(), 0);
        check_val("rnd_bit_cnt",     bit_cnt,     0);
        check_val("rnd_end_busy",    busy,        0);
        check_val("rnd_some_frames", frames > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
